// File: rtl/video_text.sv
// video_text: text-mode pixel generator behind video_sync.
// Fetches char/attr and glyph rows, shifts out 2-bit RGB.
module video_text #(
  parameter int COLS = 80,
  parameter int TA_W = 12
) (
  input  logic            fclk,
  input  logic            rst_n,
  input  logic            pix_stb,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic            i_hpix,
  input  logic            i_vpix,
  input  logic            v_init,
  input  logic            h_init,
  input  logic            h_step,
  input  logic            h_char,
  output logic [TA_W-1:0] txt_addr,
  output logic            txt_rd,
  input  logic [15:0]     txt_data,
  output logic [10:0]     font_addr,
  input  logic [7:0]      font_data,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic [1:0]      red,
  output logic [1:0]      grn,
  output logic [1:0]      blu
);

  typedef enum logic [1:0] {
    IDLE,
    TXT,
    FNT,
    DONE
  } state_e;

  localparam logic [TA_W-1:0] COLS_W = TA_W'(COLS);

  state_e          state_q, state_d;
  logic [2:0]      line_q, line_d;
  logic [TA_W-1:0] row_base_q, row_base_d;
  logic            first_q, first_d;
  logic [TA_W-1:0] col_q, col_d;
  logic [TA_W-1:0] txt_addr_q, txt_addr_d;
  logic            txt_rd_q, txt_rd_d;
  logic [10:0]     font_addr_q, font_addr_d;
  logic [7:0]      nxt_attr_q, nxt_attr_d;
  logic [7:0]      nxt_bits_q, nxt_bits_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      cur_attr_q, cur_attr_d;
  logic [5:0]      rgb_q, rgb_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            start;
  logic            pix;
  logic [7:0]      attr;
  logic            unused_ok;

  // Bit 7 of the shifter is already on screen; it is never re-read.
  assign unused_ok = h_step ^ shift_q[7];
  assign start     = h_init | h_char;

  // Expand a {R,G,B} triple into three 2-bit channels.
  function automatic logic [5:0] rgb_of(
    input logic [2:0] c,
    input logic       br
  );
    return {c[2], c[2] & br,
            c[1], c[1] & br,
            c[0], c[0] & br};
  endfunction

  // Line, text-row base and column tracking.
  always_comb begin
    line_d     = line_q;
    row_base_d = row_base_q;
    first_d    = first_q;
    col_d      = col_q;
    if (v_init) begin
      line_d     = '0;
      row_base_d = '0;
      first_d    = 1'b1;
    end else if (h_init) begin
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        line_d = line_q + 3'd1;
        if (line_q == 3'd7) begin
          row_base_d = row_base_q + COLS_W;
        end
      end
    end
    if (h_init) begin
      col_d = '0;
    end else if (h_char) begin
      col_d = col_q + TA_W'(1);
    end
  end

  // Fetch sequencer: text word, then glyph row; a new start aborts.
  always_comb begin
    state_d     = state_q;
    txt_rd_d    = 1'b0;
    txt_addr_d  = txt_addr_q;
    font_addr_d = font_addr_q;
    nxt_attr_d  = nxt_attr_q;
    nxt_bits_d  = nxt_bits_q;
    if (start) begin
      state_d    = TXT;
      txt_rd_d   = 1'b1;
      txt_addr_d = row_base_d + col_d;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        TXT:  state_d = FNT;
        FNT: begin
          nxt_attr_d  = txt_data[15:8];
          font_addr_d = {txt_data[7:0], line_q};
          state_d     = DONE;
        end
        DONE: begin
          nxt_bits_d = font_data;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pixel shifter, attribute decode and strobe-gated outputs.
  always_comb begin
    pix        = h_char ? nxt_bits_q[7] : shift_q[6];
    attr       = h_char ? nxt_attr_q : cur_attr_q;
    shift_d    = shift_q;
    cur_attr_d = cur_attr_q;
    rgb_d      = rgb_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    if (pix_stb) begin
      if (h_char) begin
        shift_d    = nxt_bits_q;
        cur_attr_d = nxt_attr_q;
      end else begin
        shift_d = {shift_q[6:0], 1'b0};
      end
      if (i_hpix & i_vpix) begin
        rgb_d = pix ? rgb_of(attr[2:0], attr[3])
                    : rgb_of(attr[6:4], attr[7]);
      end else begin
        rgb_d = '0;
      end
      hs_d = i_hsync;
      vs_d = i_vsync;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_q      <= '0;
      row_base_q  <= '0;
      first_q     <= 1'b1;
      col_q       <= '0;
      txt_addr_q  <= '0;
      txt_rd_q    <= 1'b0;
      font_addr_q <= '0;
      nxt_attr_q  <= '0;
      nxt_bits_q  <= '0;
      shift_q     <= '0;
      cur_attr_q  <= '0;
      rgb_q       <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      row_base_q  <= row_base_d;
      first_q     <= first_d;
      col_q       <= col_d;
      txt_addr_q  <= txt_addr_d;
      txt_rd_q    <= txt_rd_d;
      font_addr_q <= font_addr_d;
      nxt_attr_q  <= nxt_attr_d;
      nxt_bits_q  <= nxt_bits_d;
      shift_q     <= shift_d;
      cur_attr_q  <= cur_attr_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign txt_addr  = txt_addr_q;
  assign txt_rd    = txt_rd_q;
  assign font_addr = font_addr_q;
  assign red       = rgb_q[5:4];
  assign grn       = rgb_q[3:2];
  assign blu       = rgb_q[1:0];
  assign o_hsync   = hs_q;
  assign o_vsync   = vs_q;

endmodule

// File: tb/tb_video_text.sv
// tb_video_text: random frames against a cell-level reference.
// Expected pixels and fetch addresses go through scoreboard queues.
module tb_video_text;

  localparam int COLS = 80;
  localparam int TA_W = 12;

  logic        fclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_stb = 1'b0;
  logic        i_hsync = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_hpix = 1'b0;
  logic        i_vpix = 1'b0;
  logic        v_init = 1'b0;
  logic        h_init = 1'b0;
  logic        h_step = 1'b0;
  logic        h_char = 1'b0;
  logic [11:0] txt_addr;
  logic        txt_rd;
  logic [15:0] txt_data = 16'h0;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        o_hsync;
  logic        o_vsync;
  logic [1:0]  red;
  logic [1:0]  grn;
  logic [1:0]  blu;

  always #5 fclk = ~fclk;

  video_text #(
    .COLS(COLS),
    .TA_W(TA_W)
  ) dut (
    .fclk     (fclk),
    .rst_n    (rst_n),
    .pix_stb  (pix_stb),
    .i_hsync  (i_hsync),
    .i_vsync  (i_vsync),
    .i_hpix   (i_hpix),
    .i_vpix   (i_vpix),
    .v_init   (v_init),
    .h_init   (h_init),
    .h_step   (h_step),
    .h_char   (h_char),
    .txt_addr (txt_addr),
    .txt_rd   (txt_rd),
    .txt_data (txt_data),
    .font_addr(font_addr),
    .font_data(font_data),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .red      (red),
    .grn      (grn),
    .blu      (blu)
  );

  logic [15:0] txt_mem [4096];
  logic [7:0]  font_mem [2048];

  always @(posedge fclk) begin
    if (txt_rd) txt_data <= txt_mem[txt_addr];
  end
  assign font_data = font_mem[font_addr];

  typedef struct packed {
    logic [11:0] addr;
    logic [2:0]  line;
  } fetch_t;

  fetch_t     fq[$];
  logic [7:0] pq[$];
  int         errors = 0;
  int         checks = 0;
  int         n_line = -1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference: colour of pixel k of a cell, from attribute rules.
  function automatic logic [7:0] exp_px(
    input logic [15:0] t,
    input logic [2:0]  ln,
    input int          k,
    input logic        win,
    input logic        hs,
    input logic        vs
  );
    logic [7:0] g;
    logic       on;
    logic [2:0] c;
    logic       br;
    logic [1:0] lv;
    logic [5:0] rgb;
    g   = font_mem[{t[7:0], ln}];
    on  = g[7-k];
    c   = on ? t[10:8] : t[14:12];
    br  = on ? t[11] : t[15];
    lv  = br ? 2'b11 : 2'b10;
    rgb = {c[2] ? lv : 2'b00,
           c[1] ? lv : 2'b00,
           c[0] ? lv : 2'b00};
    if (!win) rgb = '0;
    return {rgb, hs, vs};
  endfunction

  // Monitor: pops expectations whenever the DUT presents output.
  logic        stb_seen = 1'b0;
  logic        rst_seen = 1'b1;
  logic [7:0]  cur;
  logic [7:0]  last = 8'h0;
  logic [10:0] fa_exp = 11'h0;
  int          fa_cnt = 0;
  fetch_t      f;

  always @(posedge fclk) begin
    stb_seen <= pix_stb;
    rst_seen <= !rst_n;
  end

  always @(negedge fclk) begin
    cur = {red, grn, blu, o_hsync, o_vsync};
    if (rst_seen) begin
      fa_cnt = 0;
    end else begin
      if (stb_seen) begin
        if (pq.size() == 0) begin
          chk("pix_extra", 32'(cur), 32'hDEAD);
        end else begin
          chk("pixel", 32'(cur), 32'(pq.pop_front()));
        end
      end else begin
        chk("hold", 32'(cur), 32'(last));
      end
      if (txt_rd) begin
        if (fq.size() == 0) begin
          chk("rd_extra", 32'(txt_addr), 32'hDEAD);
        end else begin
          f = fq.pop_front();
          chk("txt_addr", 32'(txt_addr), 32'(f.addr));
          fa_exp = {txt_mem[f.addr][7:0], f.line};
          fa_cnt = 2;
        end
      end else if (fa_cnt > 0) begin
        fa_cnt--;
        if (fa_cnt == 0) begin
          chk("font_addr", 32'(font_addr), 32'(fa_exp));
        end
      end
    end
    last = cur;
  end

  // frc: 0 random window, 1 forced visible, 2 forced blank.
  task automatic pixel(input logic hc, input logic [15:0] t,
                       input logic [2:0] ln, input int k,
                       input int frc);
    logic hp, vp, hs, vs;
    hp = 1'($urandom_range(7) != 0);
    vp = 1'($urandom_range(15) != 0);
    hs = 1'($urandom_range(1));
    vs = 1'($urandom_range(1));
    if (frc == 1) begin
      hp = 1'b1;
      vp = 1'b1;
    end else if (frc == 2) begin
      hp = 1'b0;
    end
    @(negedge fclk);
    h_init  = 1'b0;
    pix_stb = 1'b1;
    h_char  = hc;
    i_hpix  = hp;
    i_vpix  = vp;
    i_hsync = hs;
    i_vsync = vs;
    pq.push_back(exp_px(t, ln, k, hp & vp, hs, vs));
    @(negedge fclk);
    pix_stb = 1'b0;
    h_char  = 1'b0;
    repeat ($urandom_range(1)) @(negedge fclk);
  endtask

  task automatic vinit();
    @(negedge fclk);
    v_init = 1'b1;
    @(negedge fclk);
    v_init = 1'b0;
    n_line = -1;
  endtask

  // mode: 0 normal, 1 h_char right after h_init,
  // 2 whole line blanked, 3 cell 0 forced visible.
  task automatic line(input int ncell, input int mode);
    logic [11:0] base;
    logic [2:0]  ln;
    logic [15:0] t;
    int          frc;
    n_line++;
    base = 12'(((n_line / 8) * COLS) % 4096);
    ln   = 3'(n_line % 8);
    @(negedge fclk);
    h_init = 1'b1;
    fq.push_back({base, ln});
    if (mode != 1) begin
      @(negedge fclk);
      h_init = 1'b0;
      repeat (2) @(negedge fclk);
    end
    for (int c = 0; c < ncell; c++) begin
      t   = txt_mem[12'(base + 12'(c))];
      frc = 0;
      if (mode == 2) frc = 2;
      if (mode == 1 && c == 0) frc = 2;
      if (mode == 3 && c == 0) frc = 1;
      for (int k = 0; k < 8; k++) begin
        if (k == 0) fq.push_back({12'(base + 12'(c + 1)), ln});
        pixel(k == 0, t, ln, k, frc);
      end
    end
    pixel(1'b0, 16'h0, 3'd0, 0, 2);
    pixel(1'b0, 16'h0, 3'd0, 0, 2);
  endtask

  task automatic reset_mid();
    vinit();
    n_line = 0;
    @(negedge fclk);
    h_init = 1'b1;
    fq.push_back({12'd0, 3'd0});
    @(negedge fclk);
    h_init = 1'b0;
    repeat (2) @(negedge fclk);
    fq.push_back({12'd1, 3'd0});
    @(negedge fclk);
    pix_stb = 1'b1;
    h_char  = 1'b1;
    i_hpix  = 1'b1;
    i_vpix  = 1'b1;
    i_hsync = 1'b1;
    i_vsync = 1'b1;
    pq.push_back(exp_px(txt_mem[0], 3'd0, 0, 1'b1, 1'b1, 1'b1));
    @(negedge fclk);
    pix_stb = 1'b0;
    h_char  = 1'b0;
    rst_n   = 1'b0;
    @(negedge fclk);
    chk("mrst_out", 32'({red, grn, blu, o_hsync, o_vsync}), 32'h0);
    chk("mrst_rd", 32'(txt_rd), 32'h0);
    chk("mrst_taddr", 32'(txt_addr), 32'h0);
    chk("mrst_faddr", 32'(font_addr), 32'h0);
    rst_n  = 1'b1;
    n_line = -1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) txt_mem[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
    txt_mem[0]            = 16'h1F41;
    font_mem[{8'h41, 3'd0}] = 8'b1010_0000;
    txt_mem[1]            = 16'h0742;
    font_mem[{8'h42, 3'd2}] = 8'hFF;

    repeat (3) @(negedge fclk);
    chk("rst_out", 32'({red, grn, blu, o_hsync, o_vsync}), 32'h0);
    chk("rst_rd", 32'(txt_rd), 32'h0);
    chk("rst_taddr", 32'(txt_addr), 32'h0);
    chk("rst_faddr", 32'(font_addr), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge fclk);

    vinit();
    line(80, 3);
    line(2, 0);
    line(2, 2);
    line(2, 1);
    for (int n = 4; n < 10; n++) line(2, 0);

    repeat (8) @(negedge fclk);
    reset_mid();
    repeat (4) @(negedge fclk);

    vinit();
    for (int n = 0; n < 416; n++) line((n >= 408) ? 24 : 1, 0);

    repeat (20) @(negedge fclk);
    chk("pix_drain", 32'(pq.size()), 32'h0);
    chk("rd_drain", 32'(fq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
